// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Time-multiplexes NDIG parallel 7-segment patterns onto one shared segment
// bus with one-hot digit enables. Each digit slot begins with a blanked
// window to stop ghosting, followed by a PWM-scaled lit window. Patterns and
// brightness are captured once per frame so a message change never tears.
module seg7_scan_mux #(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int BLANK_CYC   = 16,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1,
    localparam int DW         = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [6:0]    led [NDIG-1:0],
    input  logic          en,
    input  logic [3:0]    bright,
    output logic [6:0]    seg,
    output logic [NDIG-1:0] an,
    output logic [DW-1:0] digit_idx,
    output logic          frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int LW = SW + 5;

    localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]   DIG_LAST  = DW'(NDIG - 1);
    localparam logic [6:0]      SEG_OFF   = {7{SEG_ACT_LOW}};
    localparam logic [NDIG-1:0] AN_OFF    = {NDIG{AN_ACT_LOW}};

    logic [SW-1:0]   slot_cnt, slot_nxt;
    logic [DW-1:0]   digit, digit_nxt;
    logic [6:0]      led_sh [NDIG-1:0];
    logic [3:0]      bright_sh;
    logic            frame_start;
    logic            slot_wrap;

    logic [LW-1:0]   on_prod;
    logic [LW-1:0]   on_len;
    logic [LW-1:0]   lit_end;
    logic [LW-1:0]   slot_ext;
    logic            lit;
    logic [NDIG-1:0] an_hot;

    // Counter successors: slot wraps at SCAN_DIV-1 and carries into digit.
    always_comb begin
        slot_wrap   = (slot_cnt == SLOT_LAST);
        frame_start = (slot_cnt == '0) && (digit == '0);
        slot_nxt    = slot_wrap ? '0 : slot_cnt + 1'b1;
        digit_nxt   = digit;
        if (slot_wrap) begin
            digit_nxt = (digit == DIG_LAST) ? '0 : digit + 1'b1;
        end
    end

    // Lit-window decode from the captured brightness; a zero-length window
    // is stretched to one cycle so bright=0 still shows a dim digit.
    always_comb begin
        on_prod  = LW'(SCAN_DIV - BLANK_CYC) * LW'({1'b0, bright_sh} + 5'd1);
        on_len   = on_prod >> 4;
        if (on_len == '0) begin
            on_len = LW'(1);
        end
        lit_end  = LW'(BLANK_CYC) + on_len;
        slot_ext = LW'(slot_cnt);
        lit      = (slot_ext >= LW'(BLANK_CYC)) && (slot_ext < lit_end);
        an_hot   = NDIG'(1) << digit;
    end

    // Slot and digit counters; held at zero while scanning is disabled.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else if (!en) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else begin
            slot_cnt <= slot_nxt;
            digit    <= digit_nxt;
        end
    end

    // Frame-synchronous capture of patterns and brightness.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < NDIG; i++) begin
                led_sh[i] <= '0;
            end
            bright_sh <= '0;
        end else if (en && frame_start) begin
            for (int i = 0; i < NDIG; i++) begin
                led_sh[i] <= led[i];
            end
            bright_sh <= bright;
        end
    end

    // Registered outputs; seg and an are written together so they never skew.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= lit ? (led_sh[digit] ^ SEG_OFF) : SEG_OFF;
            an         <= lit ? (an_hot ^ AN_OFF) : AN_OFF;
            digit_idx  <= digit;
            frame_done <= slot_wrap && (digit == DIG_LAST);
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with NDIG=4, SCAN_DIV=20, BLANK_CYC=4,
// active-low segments and anodes.
module tb_seg7_scan_mux;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [6:0] led [3:0];
    logic       en;
    logic [3:0] bright;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int an_bad  = 0;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        logic       fd;
    } vec_t;

    vec_t vecs [12];

    seg7_scan_mux #(
        .NDIG(4), .SCAN_DIV(20), .BLANK_CYC(4),
        .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_b(rst_b), .led(led), .en(en), .bright(bright),
        .seg(seg), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        if ($countones(~an) > 1) an_bad++;
    endtask

    task automatic tick_to(input int target);
        while (k < target) tick();
    endtask

    // One edge with en=0 parks the counters at frame start.
    task automatic restart_frame();
        en = 1'b0;
        tick();
        en = 1'b1;
        k = 0;
    endtask

    task automatic count_lit(input int n, output int cnt, output int first);
        cnt = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (an != 4'hF) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
    endtask

    int cnt, first, fd_cnt;

    initial begin
        // After release, output at edge k reflects scan position p=k-1.
        vecs[0]  = '{k:1,   an:4'hF, seg:7'h7F, idx:2'd0, fd:1'b0};
        vecs[1]  = '{k:4,   an:4'hF, seg:7'h7F, idx:2'd0, fd:1'b0};
        vecs[2]  = '{k:5,   an:4'hE, seg:7'h40, idx:2'd0, fd:1'b0};
        vecs[3]  = '{k:20,  an:4'hE, seg:7'h40, idx:2'd0, fd:1'b0};
        vecs[4]  = '{k:21,  an:4'hF, seg:7'h7F, idx:2'd1, fd:1'b0};
        vecs[5]  = '{k:25,  an:4'hD, seg:7'h79, idx:2'd1, fd:1'b0};
        vecs[6]  = '{k:45,  an:4'hB, seg:7'h30, idx:2'd2, fd:1'b0};
        vecs[7]  = '{k:65,  an:4'h7, seg:7'h24, idx:2'd3, fd:1'b0};
        vecs[8]  = '{k:80,  an:4'h7, seg:7'h24, idx:2'd3, fd:1'b1};
        vecs[9]  = '{k:81,  an:4'hF, seg:7'h7F, idx:2'd0, fd:1'b0};
        vecs[10] = '{k:85,  an:4'hE, seg:7'h40, idx:2'd0, fd:1'b0};
        vecs[11] = '{k:160, an:4'h7, seg:7'h24, idx:2'd3, fd:1'b1};

        // Reset held with en=1 and all segments requested on.
        rst_b = 1'b0;
        en = 1'b1;
        bright = 4'd15;
        for (int i = 0; i < 4; i++) led[i] = 7'h7F;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_fd", 32'(frame_done), 32'h0);
            chk("rst_idx", 32'(digit_idx), 32'h0);
        end

        // Full-brightness scan.
        led[3] = 7'h5B; led[2] = 7'h4F; led[1] = 7'h06; led[0] = 7'h3F;
        rst_b = 1'b1;
        k = 0;
        fd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < vecs[i].k) begin
                tick();
                if (frame_done) fd_cnt++;
            end
            chk($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
            chk($sformatf("vec%0d_idx", i), 32'(digit_idx), 32'(vecs[i].idx));
            chk($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(vecs[i].fd));
        end
        chk("fd_pulses_160", 32'(fd_cnt), 32'd2);

        // Brightness arithmetic over two frames.
        bright = 4'd7;
        restart_frame();
        count_lit(160, cnt, first);
        chk("bright7_count", 32'(cnt), 32'd64);
        bright = 4'd0;
        restart_frame();
        count_lit(160, cnt, first);
        chk("bright0_count", 32'(cnt), 32'd8);
        chk("bright0_first", 32'(first), 32'd5);

        // Tear-free update: led[3] changes while digit 1 is displayed.
        bright = 4'd15;
        restart_frame();
        tick_to(25);
        chk("tear_mid_an", 32'(an), 32'hD);
        led[3] = 7'h66;
        tick_to(65);
        chk("tear_cur_an", 32'(an), 32'h7);
        chk("tear_cur_seg", 32'(seg), 32'h24);
        tick_to(145);
        chk("tear_next_an", 32'(an), 32'h7);
        chk("tear_next_seg", 32'(seg), 32'h19);

        // Enable drop during digit 2's lit window.
        restart_frame();
        tick_to(45);
        chk("endrop_pre_an", 32'(an), 32'hB);
        en = 1'b0;
        tick();
        chk("endrop_seg", 32'(seg), 32'h7F);
        chk("endrop_an", 32'(an), 32'hF);
        chk("endrop_fd", 32'(frame_done), 32'h0);
        led[0] = 7'h6D;
        fd_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (frame_done || an != 4'hF) fd_cnt++;
        end
        chk("endrop_idle", 32'(fd_cnt), 32'd0);
        en = 1'b1;
        k = 0;
        tick();
        chk("enup_idx", 32'(digit_idx), 32'h0);
        chk("enup_dark1", 32'(an), 32'hF);
        tick_to(4);
        chk("enup_dark4", 32'(an), 32'hF);
        tick_to(5);
        chk("enup_lit_an", 32'(an), 32'hE);
        chk("enup_lit_seg", 32'(seg), 32'h12);

        // Reset pulse during digit 3's lit window.
        tick_to(65);
        chk("rstmid_pre_an", 32'(an), 32'h7);
        rst_b = 1'b0;
        tick();
        chk("rstmid_seg", 32'(seg), 32'h7F);
        chk("rstmid_an", 32'(an), 32'hF);
        chk("rstmid_idx", 32'(digit_idx), 32'h0);
        chk("rstmid_fd", 32'(frame_done), 32'h0);
        rst_b = 1'b1;
        k = 0;
        tick();
        chk("rstrel_idx", 32'(digit_idx), 32'h0);
        chk("rstrel_an", 32'(an), 32'hF);
        tick_to(5);
        chk("rstrel_lit_an", 32'(an), 32'hE);
        chk("rstrel_lit_seg", 32'(seg), 32'h12);
        tick_to(25);
        chk("rstrel_d1_an", 32'(an), 32'hD);

        chk("an_onehot", 32'(an_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage for the birthday-message block.
- Takes the parallel per-digit 7-segment patterns (`led[3:0]`, 7 bits each) and time-multiplexes them onto one shared segment bus with one-hot digit enables, as a physical common-anode 4-digit display needs.
- Adds inter-digit blanking to prevent ghosting, brightness PWM, and frame-synchronous input capture so a message change never tears mid-frame.

Parameters:
- NDIG, 4, number of digits scanned.
- SCAN_DIV, 1000, clk cycles per digit slot (≥2).
- BLANK_CYC, 16, blanked cycles at the start of each slot (< SCAN_DIV).
- SEG_ACT_LOW, 1, 1 = seg output inverted (active-low segments).
- AN_ACT_LOW, 1, 1 = an output inverted (active-low digit enables).

Ports:
- clk  in  1  system clock.
- rst_b  in  1  synchronous active-low reset.
- led  in  7 x NDIG (unpacked array [NDIG-1:0] of [6:0])  per-digit pattern, active-high, bit0 = segment a.
- en  in  1  scan enable.
- bright  in  4  brightness code 0..15.
- seg  out  7  shared segment bus.
- an  out  NDIG  digit enables, one-hot when lit.
- digit_idx  out  $clog2(NDIG)  digit currently being scanned.
- frame_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_b, sampled only on the rising clk edge.
- Reset values (applied on the first edge with rst_b=0; reset mid-scan aborts immediately):
  - slot_cnt=0, digit=0, shadow patterns=0, shadow bright=0.
  - seg = all segments off (7'h7F if SEG_ACT_LOW, else 0).
  - an = all off (all-ones if AN_ACT_LOW, else 0).
  - digit_idx=0, frame_done=0.
- Counters:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit advances 0→1→…→NDIG-1→0.
  - Frame length = NDIG*SCAN_DIV cycles.
- Frame capture:
  - On any edge where en=1, digit=0 and slot_cnt=0, copy all led entries and bright into shadow registers.
  - Display uses only the shadow values.
  - led or bright changes mid-frame are invisible until the next frame start.
- Lit window:
  - on_len = ((SCAN_DIV-BLANK_CYC)*(bright_sh+1)) >> 4, integer truncation, computed at width ≥ $clog2(SCAN_DIV)+5.
  - If on_len=0, force on_len=1.
  - Digit is lit iff BLANK_CYC ≤ slot_cnt < BLANK_CYC+on_len.
  - Otherwise seg and an are both off.
- Output timing:
  - seg, an, digit_idx and frame_done are registered.
  - Values at edge t+1 reflect counter/shadow state after edge t, i.e. 1-cycle latency.
  - When lit: an = one-hot(digit), inverted per AN_ACT_LOW; seg = led_sh[digit], inverted per SEG_ACT_LOW.
  - Never more than one an bit active.
  - seg and an always change on the same edge; no segment-on/anode-off skew.
- frame_done: high for exactly the one cycle whose registered state is digit=NDIG-1, slot_cnt=SCAN_DIV-1.
- en behaviour:
  - While en=0: counters are held at 0 and outputs are off on the next edge.
  - frame_done=0 while en=0.
  - Shadows retain their last values.
  - On en returning to 1, the frame restarts at digit 0 with a fresh capture.
- Simultaneous events:
  - rst_b=0 overrides en.
  - With en=0 and frame start coinciding, no capture occurs.

Test Plan:
All scenarios use NDIG=4, SCAN_DIV=20, BLANK_CYC=4, SEG_ACT_LOW=1, AN_ACT_LOW=1.
1. Reset: rst_b=0 for 5 cycles, led all 7'h7F, en=1 → seg=7'h7F, an=4'hF, frame_done=0, digit_idx=0 throughout.
2. Full-brightness scan: release reset, bright=15, led={7'h5B,7'h4F,7'h06,7'h3F} for digits 3..0.
   - Per slot: 4 cycles dark, then 16 cycles lit.
   - Digit 0 lit shows an=4'b1110, seg=7'h40.
   - Digit 1 lit shows an=4'b1101, seg=7'h79.
   - Scan order is 0,1,2,3.
   - frame_done pulses every 80 cycles.
3. Brightness arithmetic:
   - bright=7 → 8 lit cycles per slot.
   - bright=0 → exactly 1 lit cycle per slot, at slot_cnt=4 (+1 latency).
   - Verify by counting active-an cycles over 2 frames: 64 and 8 respectively.
4. Tear-free update: change led[3] from 7'h5B to 7'h66 while digit 1 is displayed → digit 3 in the current frame still shows seg=7'h24; the next frame shows seg=7'h19.
5. Enable drop: en=0 during digit 2's lit window.
   - Next edge: seg=7'h7F, an=4'hF, frame_done stays 0.
   - en=1 again: digit_idx=0, 4 dark cycles, then digit 0 lit with freshly captured led.
6. Reset mid-scan: rst_b=0 for one cycle during digit 3's lit window → next edge all outputs at reset values; after release the scan restarts at digit 0 with shadows = 0 (segments off) until the first capture.
